instruction_loader: RTL
=======================

# instruction_loader

Sequencer that fills the instruction memory before execution. It accepts a byte stream over a valid/ready handshake, assembles bytes into instruction words, and issues one-cycle write strobes to the instruction memory's write port. Loading ends at the halt word (all zeros) or when memory is full. It sits between the debug/UART receive path and the IF-stage instruction memory, and owns that memory's write port during program load.

## Interface
- `WORD_SIZE_IN_BYTES`, 4, bytes per instruction word.
- `MEM_SIZE_IN_WORDS`, 10, instruction memory capacity in words.
- Byte width is `` `BYTE_SIZE `` (8) from the shared header.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  begins a load; sampled only in IDLE or DONE.
- `i_byte_valid`  in  1  `i_byte` holds valid data.
- `i_byte`  in  `BYTE_SIZE`  incoming program byte.
- `o_byte_ready`  out  1  loader can accept a byte.
- `o_instruction_write`  out  1  one-cycle write strobe to the instruction memory.
- `o_instruction`  out  `WORD_SIZE_IN_BYTES*BYTE_SIZE`  assembled word; stable whenever the strobe is high.
- `o_word_count`  out  `$clog2(MEM_SIZE_IN_WORDS+1)`  words written in the current load.
- `o_done`  out  1  load finished (halt word written or memory full).
- `o_error`  out  1  memory filled with no halt word written.

## Operation
- States:
  - IDLE -> COLLECT on `i_start`; clears the byte index, `o_word_count`, `o_done` and `o_error`.
  - COLLECT: `o_byte_ready`=1. A byte is accepted on a cycle with `i_byte_valid && o_byte_ready`. It is stored at byte index k, and k increments.
  - COLLECT -> WRITE after byte index `WORD_SIZE_IN_BYTES-1` is accepted.
  - WRITE (one cycle): `o_byte_ready`=0, `o_instruction_write`=1, `o_word_count` increments at the end of the cycle.
  - WRITE -> DONE if the word is all zeros (halt). `o_error`=0.
  - WRITE -> DONE if the incremented count equals `MEM_SIZE_IN_WORDS`. `o_error`=1. If the final word is also the halt word, halt wins and `o_error`=0.
  - Otherwise WRITE -> COLLECT with k=0.
  - DONE: `o_done`=1, `o_byte_ready`=0. Holds until `i_start`, which restarts the sequence as from IDLE.
- `i_start` in COLLECT or WRITE is ignored.
- Default byte order is little-endian: the first byte goes to bits [7:0].
- A byte presented while `o_byte_ready`=0 is not consumed. The upstream holds it.

## Timing
- Reset (asynchronous, active-low) state:
  - FSM in IDLE, byte index 0, assembly register 0.
  - All outputs 0.
  - Any partial word is discarded; no strobe is generated.
- Reset deassertion is synchronised by the system reset block. The loader acts on the first rising edge after release.
- Latency:
  - The strobe is high the cycle after the last byte of a word is accepted.
  - `o_done` rises the cycle after the WRITE cycle that ends the load.
- Throughput: maximum one word per `WORD_SIZE_IN_BYTES+1` cycles.
- `o_instruction` is registered. It keeps its value until the next word's first byte is accepted.
- `o_word_count` is never greater than `MEM_SIZE_IN_WORDS`. It does not wrap.
- The memory's own write pointer is advanced only by `o_instruction_write`. The loader generates no address.

## Configuration
- `INSTRUCTION_LOADER_BIG_ENDIAN_EN`
  - Defined: the first byte of each word fills the most significant byte, i.e. bits [W-1:W-8].
  - Undefined: little-endian, as in Operation.
- Halt detection, handshake and timing are identical in both builds.

## Test plan
- Reset mid-word: start, send 2 bytes, pulse `i_reset` low.
  - All outputs are 0 and there is no strobe.
  - A fresh start then loads correctly.
- Normal load: start, send 0x11 0x22 0x33 0x44, then 0x00 ×4.
  - First strobe carries `o_instruction`=0x44332211; second carries 0x00000000.
  - `o_word_count`=2, `o_done`=1, `o_error`=0.
- Handshake stall: hold `i_byte_valid` low for random 0–20 cycles between bytes.
  - Same words are written and no byte is duplicated.
  - `o_byte_ready`=0 in every WRITE and DONE cycle.
- Memory full: 10 non-zero words (bytes 0x01..0x28) with no halt.
  - Exactly 10 strobes, `o_word_count`=10.
  - `o_done`=1, `o_error`=1, and `o_byte_ready` stays 0 afterwards.
- Halt as the 10th word: 9 non-zero words, then zeros.
  - `o_done`=1, `o_error`=0.
- Big-endian build (`INSTRUCTION_LOADER_BIG_ENDIAN_EN` defined): send 0x11 0x22 0x33 0x44.
  - `o_instruction`=0x11223344.

Source files
------------

// File: rtl/instruction_loader_if.sv
// +----------------------------------------------------------------------------+
// | instruction_loader_if                                                      |
// | Byte-stream handshake and instruction-memory write port of the loader.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef BYTE_SIZE
`define BYTE_SIZE 8
`endif

interface instruction_loader_if #(
  parameter int WORD_SIZE_IN_BYTES = 4
);
  logic                                       i_byte_valid;
  logic [`BYTE_SIZE-1:0]                      i_byte;
  logic                                       o_byte_ready;
  logic                                       o_instruction_write;
  logic [WORD_SIZE_IN_BYTES*`BYTE_SIZE-1:0]   o_instruction;

  // Upstream byte source and instruction-memory side
  modport master (
    output i_byte_valid,
    output i_byte,
    input  o_byte_ready,
    input  o_instruction_write,
    input  o_instruction
  );

  // Loader side
  modport slave (
    input  i_byte_valid,
    input  i_byte,
    output o_byte_ready,
    output o_instruction_write,
    output o_instruction
  );
endinterface

`default_nettype wire

// File: rtl/instruction_loader.sv
// +----------------------------------------------------------------------------+
// | instruction_loader                                                         |
// | Assembles a byte stream into instruction words and strobes them into the   |
// | instruction memory until a halt word (all zeros) or memory is full.        |
// | Option: INSTRUCTION_LOADER_BIG_ENDIAN_EN puts the first byte in the MSB.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef BYTE_SIZE
`define BYTE_SIZE 8
`endif

module instruction_loader #(
  parameter int WORD_SIZE_IN_BYTES = 4,
  parameter int MEM_SIZE_IN_WORDS  = 10
) (
  input  logic                                   i_clk,
  input  logic                                   i_reset,
  input  logic                                   i_start,
  instruction_loader_if.slave                    bus,
  output logic [$clog2(MEM_SIZE_IN_WORDS+1)-1:0] o_word_count,
  output logic                                   o_done,
  output logic                                   o_error
);

  localparam int c_word_w = WORD_SIZE_IN_BYTES * `BYTE_SIZE;
  localparam int c_idx_w  = (WORD_SIZE_IN_BYTES > 1) ? $clog2(WORD_SIZE_IN_BYTES) : 1;
  localparam int c_cnt_w  = $clog2(MEM_SIZE_IN_WORDS + 1);

  localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(WORD_SIZE_IN_BYTES - 1);
  localparam logic [c_cnt_w-1:0] c_mem_words = c_cnt_w'(MEM_SIZE_IN_WORDS);

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_collect = 2'd1;
  localparam logic [1:0] c_st_write   = 2'd2;
  localparam logic [1:0] c_st_done    = 2'd3;

  logic [1:0]          r_state;
  logic [c_idx_w-1:0]  r_byte_idx;
  logic [c_word_w-1:0] r_instruction;
  logic [c_cnt_w-1:0]  r_word_count;
  logic                r_error;

  logic                w_accept;
  logic                w_halt;
  logic [c_idx_w-1:0]  w_lane;
  logic [c_cnt_w-1:0]  w_count_next;

  assign w_accept     = bus.i_byte_valid && (r_state == c_st_collect);
  assign w_halt       = (r_instruction == '0);
  assign w_count_next = r_word_count + c_cnt_w'(1);

`ifdef INSTRUCTION_LOADER_BIG_ENDIAN_EN
  assign w_lane = c_last_idx - r_byte_idx;
`else
  assign w_lane = r_byte_idx;
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= c_st_idle;
      r_byte_idx    <= '0;
      r_instruction <= '0;
      r_word_count  <= '0;
      r_error       <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle, c_st_done: begin
          if (i_start) begin
            r_state      <= c_st_collect;
            r_byte_idx   <= '0;
            r_word_count <= '0;
            r_error      <= 1'b0;
          end
        end
        c_st_collect: begin
          if (w_accept) begin
            r_instruction[int'(w_lane)*`BYTE_SIZE +: `BYTE_SIZE] <= bus.i_byte;
            if (r_byte_idx == c_last_idx) begin
              r_byte_idx <= '0;
              r_state    <= c_st_write;
            end else begin
              r_byte_idx <= r_byte_idx + c_idx_w'(1);
            end
          end
        end
        c_st_write: begin
          r_word_count <= w_count_next;
          // A halt word landing in the last slot is a clean finish, not an overflow.
          if (w_halt) begin
            r_state <= c_st_done;
            r_error <= 1'b0;
          end else if (w_count_next == c_mem_words) begin
            r_state <= c_st_done;
            r_error <= 1'b1;
          end else begin
            r_state <= c_st_collect;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign bus.o_byte_ready        = (r_state == c_st_collect);
  assign bus.o_instruction_write = (r_state == c_st_write);
  assign bus.o_instruction       = r_instruction;
  assign o_word_count            = r_word_count;
  assign o_done                  = (r_state == c_st_done);
  assign o_error                 = r_error;

endmodule

`default_nettype wire
